// File: rtl/secondary_ray_queue_if.sv
// Handshake bundle for the secondary ray queue: producer side (in_*) and
// intersection-stage side (out_*). A ray is six WIDTH-bit fixed-point words {start, dir}.
interface secondary_ray_queue_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [6*WIDTH-1:0]   in_ray;
  logic [1:0]           in_code;
  logic [3:0]           in_bounce;
  logic                 out_valid;
  logic                 out_ready;
  logic [6*WIDTH-1:0]   out_ray;
  logic [3:0]           out_bounce;

  modport master (
    output in_valid, in_ray, in_code, in_bounce, out_ready,
    input  in_ready, out_valid, out_ray, out_bounce
  );

  modport slave (
    input  in_valid, in_ray, in_code, in_bounce, out_ready,
    output in_ready, out_valid, out_ray, out_bounce
  );
endinterface

// File: rtl/secondary_ray_queue.sv
// FIFO of secondary rays between the reflection/refraction stage and intersection.
// Optional macro SECONDARY_RAY_QUEUE_DROP_COUNT_EN enables the saturating dropped-ray counter.
//
// state  | meaning
// EMPTY  | count == 0, accepting
// ACTIVE | 0 < count < DEPTH, accepting and presenting
// FULL   | count == DEPTH, not accepting
// FLUSH  | one-cycle clear, neither accepting nor presenting
module secondary_ray_queue #(
  parameter int DEPTH      = 8,
  parameter int MAX_BOUNCE = 4,
  parameter int WIDTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  secondary_ray_queue_if.slave     bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              dropped_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = 6 * WIDTH;

  typedef enum logic [1:0] {EMPTY, ACTIVE, FULL, FLUSH} state_t;

  state_t         state, state_nx;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [RW-1:0]  ray_mem    [DEPTH];
  logic [3:0]     bounce_mem [DEPTH];
  logic [4:0]     bounce_inc;
  logic           accept, keep, pop;
  logic [CW-1:0]  count_nx;

  assign bus.in_ready   = (state == EMPTY) || (state == ACTIVE);
  assign bus.out_valid  = (count != '0) && (state != FLUSH);
  // Head is gated so an empty queue shows zeros rather than stale storage.
  assign bus.out_ray    = bus.out_valid ? ray_mem[rd_ptr]    : '0;
  assign bus.out_bounce = bus.out_valid ? bounce_mem[rd_ptr] : '0;

  always_comb begin
    bounce_inc = {1'b0, bus.in_bounce} + 5'd1;
    accept     = bus.in_valid && bus.in_ready;
    keep       = accept && (bus.in_code != 2'b00) && (bounce_inc <= 5'(MAX_BOUNCE));
    pop        = bus.out_valid && bus.out_ready;
    count_nx   = count + CW'(keep) - CW'(pop);
    if (count_nx == '0)
      state_nx = EMPTY;
    else if (count_nx == CW'(DEPTH))
      state_nx = FULL;
    else
      state_nx = ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      state  <= FLUSH;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      if (keep) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && keep) begin
      ray_mem[wr_ptr]    <= bus.in_ray;
      bounce_mem[wr_ptr] <= bounce_inc[3:0];
    end
  end

`ifdef SECONDARY_RAY_QUEUE_DROP_COUNT_EN
  logic drop;
  assign drop = accept && !keep;

  always_ff @(posedge clk) begin
    if (rst)
      dropped_cnt <= '0;
    else if (!flush && drop && (dropped_cnt != 16'hFFFF))
      dropped_cnt <= dropped_cnt + 16'd1;
  end
`else
  assign dropped_cnt = '0;
`endif
endmodule

// File: tb/tb_secondary_ray_queue.sv
// Directed bench for secondary_ray_queue: vector table plus full/drain, steady-state,
// flush and reset-priority sequences.
module tb_secondary_ray_queue;
  localparam int DEPTH = 8;
  localparam int W     = 16;
  localparam int RW    = 6 * W;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [3:0]  count;
  logic [15:0] dropped_cnt;
  int          total = 0;
  int          bad   = 0;

  secondary_ray_queue_if #(.WIDTH(W)) bus ();

  secondary_ray_queue #(.DEPTH(DEPTH), .MAX_BOUNCE(4), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .count(count), .dropped_cnt(dropped_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          in_valid;
    logic [1:0]    code;
    logic [3:0]    bounce;
    logic [RW-1:0] ray;
    logic          out_ready;
    logic          e_in_ready;
    logic          e_out_valid;
    logic [3:0]    e_count;
    logic [3:0]    e_bounce;
    logic [RW-1:0] e_ray;
  } vec_t;

  vec_t vec [8];

  function automatic logic [RW-1:0] mk_ray(input int t);
    return {16'(t), 16'(t + 100), 16'(t + 200), 16'(t + 300), 16'(t + 400), 16'(t + 500)};
  endfunction

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_ray    = '0;
    bus.in_code   = 2'b00;
    bus.in_bounce = 4'd0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [RW-1:0] r, input logic [3:0] b);
    bus.in_valid  = 1'b1;
    bus.in_ray    = r;
    bus.in_code   = 2'b01;
    bus.in_bounce = b;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  logic [RW-1:0] ray_a;
  logic [RW-1:0] exp_ray_q[$];
  logic [3:0]    exp_b_q[$];
  logic [15:0]   exp_drop;

  initial begin
    // start (1.5, 0.5, 0.5), dir (-1, 0, 0) in Q8.8
    ray_a = {16'h0180, 16'h0080, 16'h0080, 16'hFF00, 16'h0000, 16'h0000};
`ifdef SECONDARY_RAY_QUEUE_DROP_COUNT_EN
    exp_drop = 16'd2;
`else
    exp_drop = 16'd0;
`endif
    //          vld code   bnc  ray        ordy  erdy evld cnt ebnc eray
    vec[0] = '{1'b1, 2'b01, 4'd0, ray_a,     1'b0, 1'b1, 1'b1, 4'd1, 4'd1, ray_a};
    vec[1] = '{1'b1, 2'b00, 4'd0, mk_ray(7), 1'b0, 1'b1, 1'b1, 4'd1, 4'd1, ray_a};
    vec[2] = '{1'b1, 2'b01, 4'd4, mk_ray(8), 1'b0, 1'b1, 1'b1, 4'd1, 4'd1, ray_a};
    vec[3] = '{1'b1, 2'b10, 4'd3, mk_ray(9), 1'b1, 1'b1, 1'b1, 4'd1, 4'd4, mk_ray(9)};
    vec[4] = '{1'b0, 2'b00, 4'd0, '0,        1'b1, 1'b1, 1'b0, 4'd0, 4'd0, '0};
    vec[5] = '{1'b1, 2'b11, 4'd2, mk_ray(10),1'b1, 1'b1, 1'b1, 4'd1, 4'd3, mk_ray(10)};
    vec[6] = '{1'b0, 2'b00, 4'd0, '0,        1'b0, 1'b1, 1'b1, 4'd1, 4'd3, mk_ray(10)};
    vec[7] = '{1'b0, 2'b00, 4'd0, '0,        1'b1, 1'b1, 1'b0, 4'd0, 4'd0, '0};

    do_reset();
    chk("rst in_ready",   RW'(bus.in_ready),   RW'(1));
    chk("rst out_valid",  RW'(bus.out_valid),  RW'(0));
    chk("rst count",      RW'(count),          RW'(0));
    chk("rst dropped",    RW'(dropped_cnt),    RW'(0));
    chk("rst out_ray",    bus.out_ray,         '0);
    chk("rst out_bounce", RW'(bus.out_bounce), RW'(0));

    for (int i = 0; i < 8; i++) begin
      bus.in_valid  = vec[i].in_valid;
      bus.in_code   = vec[i].code;
      bus.in_bounce = vec[i].bounce;
      bus.in_ray    = vec[i].ray;
      bus.out_ready = vec[i].out_ready;
      tick();
      chk($sformatf("vec%0d in_ready", i),   RW'(bus.in_ready),   RW'(vec[i].e_in_ready));
      chk($sformatf("vec%0d out_valid", i),  RW'(bus.out_valid),  RW'(vec[i].e_out_valid));
      chk($sformatf("vec%0d count", i),      RW'(count),          RW'(vec[i].e_count));
      chk($sformatf("vec%0d out_bounce", i), RW'(bus.out_bounce), RW'(vec[i].e_bounce));
      chk($sformatf("vec%0d out_ray", i),    bus.out_ray,         vec[i].e_ray);
    end
    idle_inputs();
    chk("filter dropped_cnt", RW'(dropped_cnt), RW'(exp_drop));

    // Fill to FULL, hold a 9th offer, then drain in order
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      push(mk_ray(20 + i), 4'(i % 4));
      chk($sformatf("fill%0d count", i), RW'(count), RW'(i + 1));
    end
    chk("full in_ready", RW'(bus.in_ready), RW'(0));
    bus.in_valid  = 1'b1;
    bus.in_ray    = mk_ray(99);
    bus.in_code   = 2'b01;
    bus.in_bounce = 4'd0;
    tick();
    tick();
    chk("full held offer count", RW'(count), RW'(DEPTH));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain%0d ray", i),    bus.out_ray,         mk_ray(20 + i));
      chk($sformatf("drain%0d bounce", i), RW'(bus.out_bounce), RW'((i % 4) + 1));
      tick();
    end
    chk("drained count",     RW'(count),         RW'(0));
    chk("drained out_valid", RW'(bus.out_valid), RW'(0));
    chk("drained in_ready",  RW'(bus.in_ready),  RW'(1));
    idle_inputs();

    // Steady push+pop at count=3 across several pointer wraps
    do_reset();
    exp_ray_q.delete();
    exp_b_q.delete();
    for (int i = 0; i < 3; i++) begin
      push(mk_ray(40 + i), 4'(i));
      exp_ray_q.push_back(mk_ray(40 + i));
      exp_b_q.push_back(4'(i + 1));
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_code   = 2'b01;
    for (int i = 0; i < 20; i++) begin
      bus.in_ray    = mk_ray(60 + i);
      bus.in_bounce = 4'(i % 3);
      chk($sformatf("steady%0d ray", i),    bus.out_ray,         exp_ray_q.pop_front());
      chk($sformatf("steady%0d bounce", i), RW'(bus.out_bounce), RW'(exp_b_q.pop_front()));
      exp_ray_q.push_back(mk_ray(60 + i));
      exp_b_q.push_back(4'((i % 3) + 1));
      tick();
      chk($sformatf("steady%0d count", i), RW'(count), RW'(3));
    end
    idle_inputs();

    // Flush with a concurrent offer
    do_reset();
    for (int i = 0; i < 5; i++) push(mk_ray(80 + i), 4'd0);
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_ray    = mk_ray(90);
    bus.in_code   = 2'b01;
    bus.out_ready = 1'b1;
    tick();
    chk("flush in_ready",  RW'(bus.in_ready),  RW'(0));
    chk("flush out_valid", RW'(bus.out_valid), RW'(0));
    chk("flush count",     RW'(count),         RW'(0));
    flush = 1'b0;
    tick();
    chk("post-flush in_ready",  RW'(bus.in_ready),  RW'(1));
    chk("post-flush out_valid", RW'(bus.out_valid), RW'(0));
    chk("post-flush count",     RW'(count),         RW'(0));
    idle_inputs();

    // Reset wins over flush and push on the same edge
    do_reset();
    for (int i = 0; i < 4; i++) push(mk_ray(110 + i), 4'd4);
    for (int i = 0; i < 4; i++) push(mk_ray(120 + i), 4'd1);
    chk("preload count", RW'(count), RW'(4));
    rst           = 1'b1;
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_ray    = mk_ray(130);
    bus.in_code   = 2'b01;
    bus.out_ready = 1'b1;
    tick();
    chk("rst2 in_ready",   RW'(bus.in_ready),   RW'(1));
    chk("rst2 out_valid",  RW'(bus.out_valid),  RW'(0));
    chk("rst2 count",      RW'(count),          RW'(0));
    chk("rst2 dropped",    RW'(dropped_cnt),    RW'(0));
    chk("rst2 out_ray",    bus.out_ray,         '0);
    chk("rst2 out_bounce", RW'(bus.out_bounce), RW'(0));
    rst = 1'b0;
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
